// File: rtl/pulse_timer.sv
// rtl/pulse_timer.sv - photodiode pulse width and start-time measurement
//
// Purpose: synchronises the asynchronous sensor envelope, measures each high
// pulse in clock cycles, timestamps its rising edge and strobes accepted pulses.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sensor     in   asynchronous photodiode envelope, active-high
//   duration   out  width of last accepted pulse in cycles (saturating)
//   start_time out  free-running timestamp captured at that pulse's rising edge
//   overflow   out  last accepted pulse saturated the duration counter
//   valid      out  one-cycle strobe: duration/start_time/overflow updated

`ifndef PULSE_DURATION_SIZE
`define PULSE_DURATION_SIZE 15
`endif

module pulse_timer #(
    parameter int TS_W      = 32,
    parameter int MIN_WIDTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            sensor,
    output logic [`PULSE_DURATION_SIZE:0]   duration,
    output logic [TS_W-1:0]                 start_time,
    output logic                            overflow,
    output logic                            valid
);

    localparam int DW = `PULSE_DURATION_SIZE + 1;

    typedef enum logic [1:0] {
        WAIT_LOW,
        IDLE,
        HIGH
    } state_t;

    state_t          state;
    state_t          state_next;

    logic            sync1;
    logic            sync2;
    logic            s;
    logic [1:0]      primed;
    logic [TS_W-1:0] ts;
    logic [TS_W-1:0] ts_lat;
    logic [DW-1:0]   cnt;
    logic            sat;

    logic            start_pulse;
    logic            bump;
    logic            emit;

    assign s = sync2;

    // The synchroniser flops are cleared by reset, so for two cycles after
    // reset s reads 0 regardless of the sensor. primed marks when the chain
    // again reflects the real input; WAIT_LOW ignores s until then so that a
    // pulse still high across reset is not mistaken for a fresh one.
    always_comb begin
        state_next  = state;
        start_pulse = 1'b0;
        bump        = 1'b0;
        emit        = 1'b0;
        case (state)
            WAIT_LOW: begin
                if (primed[1] && !s) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (s) begin
                    start_pulse = 1'b1;
                    state_next  = HIGH;
                end
            end
            HIGH: begin
                if (s) begin
                    bump = 1'b1;
                end else begin
                    state_next = IDLE;
                    if (cnt >= DW'(MIN_WIDTH)) begin
                        emit = 1'b1;
                    end
                end
            end
            default: begin
                state_next = WAIT_LOW;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_LOW;
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            primed     <= 2'b00;
            ts         <= '0;
            ts_lat     <= '0;
            cnt        <= '0;
            sat        <= 1'b0;
            duration   <= '0;
            start_time <= '0;
            overflow   <= 1'b0;
            valid      <= 1'b0;
        end else begin
            state  <= state_next;
            sync1  <= sensor;
            sync2  <= sync1;
            primed <= {primed[0], 1'b1};
            ts     <= ts + TS_W'(1);
            valid  <= emit;

            if (start_pulse) begin
                cnt    <= DW'(1);
                ts_lat <= ts;
                sat    <= 1'b0;
            end

            // Saturate rather than wrap so a stuck-high sensor reports all-ones.
            if (bump) begin
                if (&cnt) begin
                    sat <= 1'b1;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end

            if (emit) begin
                duration   <= cnt;
                start_time <= ts_lat;
                overflow   <= sat;
            end
        end
    end

endmodule

// File: doc/pulse_timer.md
# pulse_timer

Front-end stage of the Vive lighthouse receive path. Synchronises the raw photodiode envelope into the system clock and measures each high pulse in clock cycles. Captures a free-running timestamp at each pulse's rising edge. Emits one `valid` strobe per accepted pulse, carrying its duration and start time; the duration feeds the pulse-type classifier, and the start time feeds the downstream sweep-angle logic.

## Interface
Parameters:
- `TS_W`, default 32: width of the free-running timestamp counter and `start_time`.
- `MIN_WIDTH`, default 4: minimum accepted pulse width in cycles. Shorter pulses are glitches and are dropped.
- Duration width is fixed at `` `PULSE_DURATION_SIZE``+1 bits, from vive_constants. It is not a parameter.

Ports:
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  synchronous, active-high reset.
- `sensor`  in  1  photodiode envelope, asynchronous to `clk`, active-high.
- `duration`  out  `` `PULSE_DURATION_SIZE``+1  width of the last accepted pulse, in cycles.
- `start_time`  out  `TS_W`  timestamp captured at that pulse's rising edge.
- `overflow`  out  1  last accepted pulse saturated the duration counter.
- `valid`  out  1  one-cycle strobe: `duration`, `start_time` and `overflow` were updated this cycle.

## Operation
- Synchroniser:
  - Two-flop chain `sync1` → `sync2`; both reset to 0.
  - `s` = `sync2`. No other logic samples `sensor`.
- Timestamp `ts`:
  - Increments every cycle; resets to 0.
  - Wraps modulo 2^`TS_W` with no flag.
- FSM states: WAIT_LOW, IDLE, HIGH. Reset state is WAIT_LOW.
- WAIT_LOW:
  - Stays while `s`=1.
  - Goes to IDLE when `s`=0.
  - Guarantees that a pulse already in progress at reset, or truncated by reset, is never measured.
- IDLE:
  - On `s`=1: load `cnt`←1, `ts_lat`←`ts`, `sat`←0, go to HIGH.
  - Otherwise stay.
- HIGH while `s`=1:
  - If `cnt` is all-ones, hold it and set `sat`←1.
  - Otherwise `cnt`←`cnt`+1.
- HIGH when `s`=0, go to IDLE, and:
  - If `cnt` ≥ `MIN_WIDTH`: register `duration`←`cnt`, `start_time`←`ts_lat`, `overflow`←`sat`, and `valid`←1 for one cycle.
  - Otherwise drop the pulse: no `valid`, outputs unchanged.
- `valid` is 0 in every cycle not described above.
- `duration`, `start_time` and `overflow` hold their values between strobes.
- Reset values: all outputs 0; `cnt`, `ts_lat` and `sat` 0.
- A stuck-high sensor produces no output. The counter stays saturated until `s` falls, then one strobe is emitted with `overflow`=1.
- A single low sample between pulses is sufficient. HIGH→IDLE→HIGH is legal, and the two pulses produce two strobes.
- `rst` asserted in any state forces WAIT_LOW and clears `valid` in the same edge. A pending pulse is discarded.

## Timing
- Let `sensor` be sampled high at `clk` edges N..N+K-1 and low at edge N+K.
- Resulting events:
  - `s` is high after edges N+1..N+K.
  - The FSM enters HIGH at edge N+2; `ts_lat` = value of `ts` sampled at edge N+2.
  - `cnt`=K after edge N+K+1.
  - `valid`=1 and `duration`=K in the cycle following edge N+K+2.
- Total latency: 3 clocks from the first low sample to `valid`.
- Measured width equals the sampled width exactly, with no ±1 bias beyond sampling quantisation.
- Minimum pulse spacing for distinct strobes: 1 low sample. Throughput is one strobe per K+1 cycles at most.
- All outputs are registered; there are no combinational paths from `sensor`.

## Test plan
- Basic width: after reset, `sensor` low 5 cycles, high 10, low. Expect:
  - exactly one `valid`, 13 edges after the rising sample;
  - `duration`=10, `overflow`=0;
  - `start_time` = `ts` at edge rise+2.
- Glitch: `sensor` high for 3 cycles (`MIN_WIDTH`=4), then low. Expect no `valid` and outputs unchanged. Then a 4-cycle pulse: expect `valid` with `duration`=4.
- Saturation: `sensor` high for 2^(`` `PULSE_DURATION_SIZE``+1)+20 cycles. Expect one `valid` after the fall, `duration`=all-ones, `overflow`=1.
- Reset mid-pulse: `rst` asserted for 1 cycle at pulse cycle 6 while `sensor` stays high 20 more cycles, then low 2, then high 8. Expect no strobe for the first pulse, then one strobe with `duration`=8.
- Back-to-back: pulses of 6 and 7 cycles separated by 1 low sample. Expect two strobes, `duration`=6 then 7, with `start_time` delta = 7.
- Timestamp wrap: `TS_W`=8, pulses spaced 100 cycles apart over 600 cycles. Expect each `start_time` to equal the previous value +100 mod 256.
